// File: rtl/shift_mask_unit_if.sv
// Operand, control and result bundle for the shift-and-gate stage of the
// shift-add multiplier; the master drives operands and the slave returns results.
interface shift_mask_unit_if;
  logic [4:0]  amt;
  logic        dir64;
  logic [63:0] a_in;
  logic        dir32;
  logic [31:0] b_in;
  logic [63:0] a_sh;
  logic [31:0] b_sh;
  logic [63:0] gated;

  modport master (
    output amt, dir64, a_in, dir32, b_in,
    input  a_sh, b_sh, gated
  );

  modport slave (
    input  amt, dir64, a_in, dir32, b_in,
    output a_sh, b_sh, gated
  );
endinterface

// File: rtl/shift_mask_unit.sv
// Registered shift-and-gate stage: two logical log-shifters sharing one amount,
// with the wide result masked by bit 0 of the narrow result (the partial product).
module shift_mask_unit (
  input  logic               clk,
  input  logic               reset,
  shift_mask_unit_if.slave   bus
);

  // Five-stage logarithmic shifter; stage k moves by 2^k, direction applied per stage.
  function automatic logic [63:0] log_shift64(input logic [63:0] v,
                                              input logic [4:0]  sh,
                                              input logic        right);
    logic [63:0] s;
    s = v;
    for (int k = 0; k < 5; k++) begin
      s = sh[k] ? (right ? (s >> (32'd1 << k)) : (s << (32'd1 << k))) : s;
    end
    return s;
  endfunction

  function automatic logic [31:0] log_shift32(input logic [31:0] v,
                                              input logic [4:0]  sh,
                                              input logic        right);
    logic [31:0] s;
    s = v;
    for (int k = 0; k < 5; k++) begin
      s = sh[k] ? (right ? (s >> (32'd1 << k)) : (s << (32'd1 << k))) : s;
    end
    return s;
  endfunction

  logic [63:0] a_sh_d, a_sh_q;
  logic [31:0] b_sh_d, b_sh_q;
  logic [63:0] gated_d, gated_q;

  // Mask uses the same-cycle combinational b result so all three outputs stay consistent.
  always_comb begin
    a_sh_d  = log_shift64(bus.a_in, bus.amt, bus.dir64);
    b_sh_d  = log_shift32(bus.b_in, bus.amt, bus.dir32);
    gated_d = a_sh_d & {64{b_sh_d[0]}};
  end

  // Output registers with reset taking priority over fresh data.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh_q  <= 64'd0;
      b_sh_q  <= 32'd0;
      gated_q <= 64'd0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      gated_q <= gated_d;
    end
  end

  assign bus.a_sh  = a_sh_q;
  assign bus.b_sh  = b_sh_q;
  assign bus.gated = gated_q;

endmodule

// File: tb/tb_shift_mask_unit.sv
// Self-checking bench for shift_mask_unit: directed vector table, amount/direction
// sweep and a pipelined stream with mid-stream reset, all scoreboarded.
module tb_shift_mask_unit;

  typedef struct {
    string       name;
    logic        rst;
    logic [4:0]  amt;
    logic        d64;
    logic [63:0] a;
    logic        d32;
    logic [31:0] b;
    logic [63:0] ea;
    logic [31:0] eb;
    logic [63:0] eg;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] ea;
    logic [31:0] eb;
    logic [63:0] eg;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sb[$];
  vec_t tbl[$];

  shift_mask_unit_if bus();

  shift_mask_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference built from the plain shift operators, independent of the mux network.
  function automatic exp_t model(input string nm, input logic rst, input logic [4:0] amt,
                                 input logic d64, input logic [63:0] a,
                                 input logic d32, input logic [31:0] b);
    exp_t e;
    e.name = nm;
    if (rst) begin
      e.ea = 64'd0;
      e.eb = 32'd0;
      e.eg = 64'd0;
    end else begin
      e.ea = d64 ? (a >> amt) : (a << amt);
      e.eb = d32 ? (b >> amt) : (b << amt);
      e.eg = e.eb[0] ? e.ea : 64'd0;
    end
    return e;
  endfunction

  task automatic drive(input logic rst, input logic [4:0] amt, input logic d64,
                       input logic [63:0] a, input logic d32, input logic [31:0] b);
    reset     = rst;
    bus.amt   = amt;
    bus.dir64 = d64;
    bus.a_in  = a;
    bus.dir32 = d32;
    bus.b_in  = b;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Advance one edge, then compare outputs with the oldest pending expectation.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      check({e.name, ".a_sh"},  bus.a_sh,          e.ea);
      check({e.name, ".b_sh"},  {32'd0, bus.b_sh}, {32'd0, e.eb});
      check({e.name, ".gated"}, bus.gated,         e.eg);
    end
  endtask

  task automatic push_vec(input vec_t v);
    exp_t e;
    e.name = v.name;
    e.ea   = v.ea;
    e.eb   = v.eb;
    e.eg   = v.eg;
    drive(v.rst, v.amt, v.d64, v.a, v.d32, v.b);
    sb.push_back(e);
  endtask

  task automatic push_model(input string nm, input logic rst, input logic [4:0] amt,
                            input logic d64, input logic [63:0] a,
                            input logic d32, input logic [31:0] b);
    drive(rst, amt, d64, a, d32, b);
    sb.push_back(model(nm, rst, amt, d64, a, d32, b));
  endtask

  initial begin
    logic [63:0] ra;
    logic [31:0] rb;
    total = 0;
    bad   = 0;

    tbl.push_back('{"reset0",    1'b1, 5'd5,  1'b0, {64{1'b1}}, 1'b1, {32{1'b1}},
                    64'd0, 32'd0, 64'd0});
    tbl.push_back('{"reset1",    1'b1, 5'd5,  1'b0, {64{1'b1}}, 1'b1, {32{1'b1}},
                    64'd0, 32'd0, 64'd0});
    tbl.push_back('{"mul_set",   1'b0, 5'd3,  1'b0, 64'hF, 1'b1, 32'd13,
                    64'h78, 32'h1, 64'h78});
    tbl.push_back('{"mul_clr",   1'b0, 5'd1,  1'b0, 64'hF, 1'b1, 32'd13,
                    64'h1E, 32'h6, 64'd0});
    tbl.push_back('{"lsr_msb",   1'b0, 5'd4,  1'b0, 64'h1234, 1'b1, 32'hFFFF_FFF1,
                    64'h12340, 32'h0FFF_FFFF, 64'h12340});
    tbl.push_back('{"a_r31",     1'b0, 5'd31, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 32'd1,
                    64'h0000_0001_0000_0000, 32'h8000_0000, 64'd0});
    tbl.push_back('{"amt0",      1'b0, 5'd0,  1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 32'h1234_5679,
                    64'hDEAD_BEEF_CAFE_F00D, 32'h1234_5679, 64'hDEAD_BEEF_CAFE_F00D});
    tbl.push_back('{"a_l31",     1'b0, 5'd31, 1'b0, 64'hF, 1'b1, 32'hFFFF_FFFF,
                    64'h7_8000_0000, 32'h1, 64'h7_8000_0000});
    tbl.push_back('{"both_l31",  1'b0, 5'd31, 1'b0, {64{1'b1}}, 1'b0, 32'hFFFF_FFFF,
                    64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 64'd0});
    tbl.push_back('{"both_r31",  1'b0, 5'd31, 1'b1, {64{1'b1}}, 1'b1, 32'h8000_0000,
                    64'h1_FFFF_FFFF, 32'h1, 64'h1_FFFF_FFFF});
    tbl.push_back('{"r16",       1'b0, 5'd16, 1'b1, 64'h1_0000, 1'b1, 32'h1_0000,
                    64'h1, 32'h1, 64'h1});

    foreach (tbl[i]) begin
      push_vec(tbl[i]);
      step();
    end

    // Every amount in every direction pairing against the operator model.
    for (int amt = 0; amt < 32; amt++) begin
      for (int d = 0; d < 4; d++) begin
        ra = {$urandom, $urandom};
        rb = $urandom;
        if (d[0]) rb[amt] = 1'b1;
        push_model($sformatf("sweep_a%0d_d%0d", amt, d), 1'b0, 5'(amt), d[1], ra, d[0], rb);
        step();
      end
    end

    // Back-to-back stream with reset dropped in mid-way; each step checks the prior input.
    for (int c = 0; c < 10; c++) begin
      ra = {$urandom, $urandom};
      rb = $urandom;
      push_model($sformatf("stream%0d", c), (c == 5), 5'($urandom_range(0, 31)),
                 1'b0, ra, 1'b1, rb | 32'(c & 1));
      step();
    end

    push_model("post_rst", 1'b0, 5'd2, 1'b0, 64'h3, 1'b1, 32'h4);
    step();

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_left: got %0d entries want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
